stream_minmax: RTL and testbench
================================

// Module: stream_minmax
// PURPOSE
//   Streaming signed min/max tracker. It sits downstream of comparator_lt and
//   comparator_eq and instantiates one of each per tracked extreme.
//   - Accepts a frame of N-bit two's-complement samples on a valid/ready input.
//   - After the frame's last sample, emits min, max, their indices and the sample count.
//   - All magnitude decisions come from the comparator instances. No behavioural '<' on data.
// PARAMETERS
//   N        32  sample width, signed two's complement
//   COUNT_W  8   width of index/count fields; max frame length = 2**COUNT_W
// PORTS
//   clk          in   1        single clock; all state updates on posedge
//   rst          in   1        synchronous, active-high reset
//   in_valid     in   1        sample present on in_data
//   in_ready     out  1        block can accept a sample this cycle
//   in_data      in   N        signed sample
//   in_last      in   1        qualifies in_data as final sample of frame
//   out_valid    out  1        result fields valid
//   out_ready    in   1        consumer accepts result this cycle
//   out_min      out  N        smallest sample of frame (signed)
//   out_max      out  N        largest sample of frame (signed)
//   out_min_idx  out  COUNT_W  0-based index of first occurrence of min
//   out_max_idx  out  COUNT_W  0-based index of first occurrence of max
//   out_count    out  COUNT_W  samples in frame minus 1
//   out_trunc    out  1        frame closed by length limit, not by in_last
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Handshakes
//   - Accept = in_valid & in_ready. Result transfer = out_valid & out_ready.
//   - in_ready = 1 in S_FIRST and S_ACC, 0 in S_HOLD.
//   States
//   - S_FIRST: waiting for sample 0.
//     On accept: min=max=in_data, both idx=0, cnt=0.
//     Next state: S_HOLD if in_last, else S_ACC.
//   - S_ACC: on accept, cnt+1.
//     - min <= in_data only if lt(in_data, min).
//     - max <= in_data only if lt(max, in_data).
//     - Ties keep the earlier value and index (strict compare).
//     - Each idx takes the new cnt when its value updates.
//     - Go to S_HOLD if in_last, or if new cnt == 2**COUNT_W-1; the latter sets trunc.
//   - S_HOLD: out_valid=1. Outputs stable until transfer, then go to S_FIRST.
//     No same-cycle input accept.
//   Timing
//   - out_valid rises the cycle after the closing accept.
//   - Minimum frame period: L accepts + 1 hold cycle.
//   Reset
//   - out_valid=0, in_ready=1 (S_FIRST).
//   - out_min=out_max=0; all idx, out_count and out_trunc = 0.
//   - rst mid-frame or in S_HOLD discards everything; the pending result is lost.
//   Width rules
//   - cnt never wraps; the length limit forces frame close first.
//   - Signed extremes 32'h80000000 and 32'h7FFFFFFF are ordinary values.
//   Registered state
//   - Outputs are driven directly from registers.
//   - Comparators see registered min/max against in_data.
//   - comparator_eq drives an internal tie flag only; no external effect.
// TESTING
//   1. Frame {5,-3,7,-3,7} + last on 4th index, out_ready=1
//      -> min=-3 idx=1, max=7 idx=2, count=4, trunc=0.
//   2. Single sample 32'h80000000 with last
//      -> min=max=32'h80000000, idx 0/0, count=0, out_valid next cycle.
//   3. Frame {32'h70000000, 32'h90000000} -> min=32'h90000000, max=32'h70000000
//      (signed order, not unsigned).
//   4. out_ready=0 for 5 cycles in S_HOLD with in_valid=1
//      -> in_ready=0, outputs stable, no sample consumed. Released once out_ready=1.
//   5. COUNT_W=3, 10 samples, no last -> first result count=7, trunc=1.
//      Samples 8-9 start a new frame.
//   6. rst asserted after 3 accepts -> next cycle out_valid=0, in_ready=1.
//      A new 2-sample frame reports count=1 with no stale data.

Source files
------------

// File: rtl/stream_minmax.sv
// Streaming signed min/max tracker: per frame reports extremes, first-occurrence indices and
// sample count. All data ordering comes from the comparator instances.

module comparator_lt #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_lt
);
    assign o_lt = $signed(i_a) < $signed(i_b);
endmodule

module comparator_eq #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_eq
);
    assign o_eq = (i_a == i_b);
endmodule

module stream_minmax #(
    parameter int unsigned N       = 32,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_min,
    output logic [N-1:0]       out_max,
    output logic [COUNT_W-1:0] out_min_idx,
    output logic [COUNT_W-1:0] out_max_idx,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_trunc
);
    typedef enum logic [1:0] {StFirst, StAcc, StHold} state_e;

    state_e               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [N-1:0]         r_min;
    logic [N-1:0]         r_max;
    logic [COUNT_W-1:0]   r_min_idx;
    logic [COUNT_W-1:0]   r_max_idx;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_trunc;

    logic                 w_accept;
    logic                 w_lt_min;
    logic                 w_lt_max;
    logic                 w_eq_min;
    logic                 w_eq_max;
    logic                 w_min_upd;
    logic                 w_max_upd;
    logic [COUNT_W-1:0]   w_cnt_next;
    logic                 w_at_limit;

    comparator_lt #(.N(N)) u_lt_min (.i_a(in_data), .i_b(r_min),   .o_lt(w_lt_min));
    comparator_lt #(.N(N)) u_lt_max (.i_a(r_max),   .i_b(in_data), .o_lt(w_lt_max));
    comparator_eq #(.N(N)) u_eq_min (.i_a(in_data), .i_b(r_min),   .o_eq(w_eq_min));
    comparator_eq #(.N(N)) u_eq_max (.i_a(r_max),   .i_b(in_data), .o_eq(w_eq_max));

    // Tie flags only reinforce the strict compare: equal samples never displace an extreme.
    assign w_min_upd  = w_lt_min & ~w_eq_min;
    assign w_max_upd  = w_lt_max & ~w_eq_max;
    assign w_accept   = in_valid & r_in_ready;
    assign w_cnt_next = r_count + COUNT_W'(1);
    assign w_at_limit = (w_cnt_next == {COUNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StFirst;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_min       <= '0;
            r_max       <= '0;
            r_min_idx   <= '0;
            r_max_idx   <= '0;
            r_count     <= '0;
            r_trunc     <= 1'b0;
        end else begin
            case (r_state)
                StFirst: begin
                    if (w_accept) begin
                        r_min     <= in_data;
                        r_max     <= in_data;
                        r_min_idx <= '0;
                        r_max_idx <= '0;
                        r_count   <= '0;
                        r_trunc   <= 1'b0;
                        if (in_last) begin
                            r_state     <= StHold;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= StAcc;
                        end
                    end
                end
                StAcc: begin
                    if (w_accept) begin
                        r_count <= w_cnt_next;
                        if (w_min_upd) begin
                            r_min     <= in_data;
                            r_min_idx <= w_cnt_next;
                        end
                        if (w_max_upd) begin
                            r_max     <= in_data;
                            r_max_idx <= w_cnt_next;
                        end
                        // Closing on the length limit keeps the counter from ever wrapping.
                        if (in_last || w_at_limit) begin
                            r_state     <= StHold;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_trunc     <= w_at_limit & ~in_last;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        r_state     <= StFirst;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StFirst;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_min     = r_min;
    assign out_max     = r_max;
    assign out_min_idx = r_min_idx;
    assign out_max_idx = r_max_idx;
    assign out_count   = r_count;
    assign out_trunc   = r_trunc;
endmodule

// File: tb/tb_stream_minmax.sv
// Directed bench for stream_minmax: a default-width instance and a COUNT_W=3 instance for the
// length-limit case.

module tb_stream_minmax;
    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_errors = 0;

    // Instance A: N=32, COUNT_W=8
    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_trunc;
    logic [31:0] a_in_data, a_out_min, a_out_max;
    logic [7:0]  a_out_min_idx, a_out_max_idx, a_out_count;

    // Instance B: N=32, COUNT_W=3
    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_trunc;
    logic [31:0] b_in_data, b_out_min, b_out_max;
    logic [2:0]  b_out_min_idx, b_out_max_idx, b_out_count;

    stream_minmax #(.N(32), .COUNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_min(a_out_min), .out_max(a_out_max),
        .out_min_idx(a_out_min_idx), .out_max_idx(a_out_max_idx),
        .out_count(a_out_count), .out_trunc(a_out_trunc)
    );

    stream_minmax #(.N(32), .COUNT_W(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_min(b_out_min), .out_max(b_out_max),
        .out_min_idx(b_out_min_idx), .out_max_idx(b_out_max_idx),
        .out_count(b_out_count), .out_trunc(b_out_trunc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting posedge.
    task automatic push(input bit sel_b, input logic [31:0] d, input logic last);
        int n = 0;
        if (sel_b) begin
            b_in_valid = 1'b1; b_in_data = d; b_in_last = last;
            while (!b_in_ready && n < 20) begin @(negedge clk); n++; end
            check("push_b_ready", {31'd0, b_in_ready}, 32'd1);
            @(negedge clk);
            b_in_valid = 1'b0; b_in_last = 1'b0;
        end else begin
            a_in_valid = 1'b1; a_in_data = d; a_in_last = last;
            while (!a_in_ready && n < 20) begin @(negedge clk); n++; end
            check("push_a_ready", {31'd0, a_in_ready}, 32'd1);
            @(negedge clk);
            a_in_valid = 1'b0; a_in_last = 1'b0;
        end
    endtask

    task automatic check_a(input string tag, input logic [31:0] mn, input logic [31:0] mn_i,
                           input logic [31:0] mx, input logic [31:0] mx_i,
                           input logic [31:0] cnt, input logic [31:0] tr);
        check({tag, "_valid"}, {31'd0, a_out_valid}, 32'd1);
        check({tag, "_min"}, a_out_min, mn);
        check({tag, "_min_idx"}, {24'd0, a_out_min_idx}, mn_i);
        check({tag, "_max"}, a_out_max, mx);
        check({tag, "_max_idx"}, {24'd0, a_out_max_idx}, mx_i);
        check({tag, "_count"}, {24'd0, a_out_count}, cnt);
        check({tag, "_trunc"}, {31'd0, a_out_trunc}, tr);
    endtask

    task automatic release_a(input string tag);
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check({tag, "_rel_valid"}, {31'd0, a_out_valid}, 32'd0);
        check({tag, "_rel_ready"}, {31'd0, a_in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] b_vals [8];
        b_vals = '{32'd4, 32'hFFFFFFFF, 32'd9, 32'd9, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFF9, 32'd0};

        rst = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_ready", {31'd0, a_in_ready}, 32'd1);
        check("rst_min", a_out_min, 32'd0);
        check("rst_max", a_out_max, 32'd0);
        check("rst_idx", {16'd0, a_out_min_idx, a_out_max_idx}, 32'd0);
        check("rst_count", {24'd0, a_out_count}, 32'd0);
        check("rst_trunc", {31'd0, a_out_trunc}, 32'd0);

        // Frame with ties on both extremes: earlier index must win.
        push(0, 32'd5, 0); push(0, 32'hFFFFFFFD, 0); push(0, 32'd7, 0);
        push(0, 32'hFFFFFFFD, 0); push(0, 32'd7, 1);
        check_a("t1", 32'hFFFFFFFD, 1, 32'd7, 2, 4, 0);
        release_a("t1");

        // Single most-negative sample.
        push(0, 32'h80000000, 1);
        check_a("t2", 32'h80000000, 0, 32'h80000000, 0, 0, 0);
        release_a("t2");

        // Signed ordering, then held result under backpressure with a waiting sample.
        push(0, 32'h70000000, 0); push(0, 32'h90000000, 1);
        check_a("t3", 32'h90000000, 1, 32'h70000000, 0, 1, 0);
        a_in_valid = 1'b1; a_in_data = 32'd1234; a_in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_in_ready", {31'd0, a_in_ready}, 32'd0);
            check("t4_valid", {31'd0, a_out_valid}, 32'd1);
            check("t4_min", a_out_min, 32'h90000000);
            check("t4_count", {24'd0, a_out_count}, 32'd1);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0; a_in_valid = 1'b0; a_in_last = 1'b0;
        check("t4_rel_valid", {31'd0, a_out_valid}, 32'd0);
        check("t4_rel_ready", {31'd0, a_in_ready}, 32'd1);
        push(0, 32'd3, 1);
        check_a("t4_next", 32'd3, 0, 32'd3, 0, 0, 0);
        release_a("t4_next");

        // Reset mid-frame discards the partial frame.
        push(0, 32'd1, 0); push(0, 32'd2, 0); push(0, 32'd3, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_valid", {31'd0, a_out_valid}, 32'd0);
        check("t6_ready", {31'd0, a_in_ready}, 32'd1);
        check("t6_count", {24'd0, a_out_count}, 32'd0);
        check("t6_min", a_out_min, 32'd0);
        push(0, 32'd10, 0); push(0, 32'hFFFFFFEC, 1);
        check_a("t6_new", 32'hFFFFFFEC, 1, 32'd10, 0, 1, 0);
        release_a("t6_new");

        // Length limit on COUNT_W=3: eight samples close the frame with trunc set.
        for (int i = 0; i < 8; i++) push(1, b_vals[i], 0);
        check("t5_valid", {31'd0, b_out_valid}, 32'd1);
        check("t5_in_ready", {31'd0, b_in_ready}, 32'd0);
        check("t5_count", {29'd0, b_out_count}, 32'd7);
        check("t5_trunc", {31'd0, b_out_trunc}, 32'd1);
        check("t5_min", b_out_min, 32'hFFFFFFF9);
        check("t5_min_idx", {29'd0, b_out_min_idx}, 32'd6);
        check("t5_max", b_out_max, 32'd9);
        check("t5_max_idx", {29'd0, b_out_max_idx}, 32'd2);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check("t5_rel_valid", {31'd0, b_out_valid}, 32'd0);
        push(1, 32'd11, 0); push(1, 32'hFFFFFFF4, 0); push(1, 32'd5, 1);
        check("t5b_valid", {31'd0, b_out_valid}, 32'd1);
        check("t5b_count", {29'd0, b_out_count}, 32'd2);
        check("t5b_trunc", {31'd0, b_out_trunc}, 32'd0);
        check("t5b_min", b_out_min, 32'hFFFFFFF4);
        check("t5b_min_idx", {29'd0, b_out_min_idx}, 32'd1);
        check("t5b_max", b_out_max, 32'd11);
        check("t5b_max_idx", {29'd0, b_out_max_idx}, 32'd0);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
